// File: rtl/mul_pipe.sv
// Pipelined A_W x B_W multiplier, signed/unsigned per transaction, valid/ready flow control.
// Define MUL_ROUND_EN to round away FRAC_W fraction bits (half-up) in the final stage.
module mul_pipe #(
    parameter int A_W    = 8,
    parameter int B_W    = 12,
    parameter int STAGES = 3,
    parameter int FRAC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] c
);
    localparam int P_W = A_W + B_W;
    localparam int NSL = (A_W + 1) / 2;
    localparam int AE  = 2 * NSL;

    // Terms left after stage s: the reduction is spread evenly, one term at the end.
    function automatic int n_of(input int s);
        int v;
        v = (NSL * (STAGES - 1 - s) + STAGES - 1) / STAGES;
        return (v < 1) ? 1 : v;
    endfunction

    // Top slice of a signed operand carries negative weight (-2..1).
    function automatic logic [P_W-1:0] pp_term(input logic [1:0] sl, input logic top,
                                               input logic [P_W-1:0] bx);
        logic [P_W-1:0] r;
        case (sl)
            2'd0:    r = '0;
            2'd1:    r = bx;
            2'd2:    r = top ? -(bx << 1) : (bx << 1);
            default: r = top ? -bx : bx + (bx << 1);
        endcase
        return r;
    endfunction

    logic [STAGES-1:0] vld_pipe;
    logic [STAGES-1:0] up;
    logic [STAGES:0]   ld;

    always_comb begin
        ld[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--)
            ld[i] = !vld_pipe[i] || ld[i+1];
        up[0] = in_valid;
        for (int i = 1; i < STAGES; i++)
            up[i] = vld_pipe[i-1];
    end

    assign in_ready  = ld[0] & ~rst;
    assign out_valid = vld_pipe[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++)
                if (ld[i]) vld_pipe[i] <= up[i];
        end
    end

    logic [AE-1:0]  a_x;
    logic [P_W-1:0] b_x;

    generate
        if (AE == A_W) begin : g_aeven
            assign a_x = a;
        end else begin : g_aodd
            assign a_x = {in_signed & a[A_W-1], a};
        end
    endgenerate

    assign b_x = {{A_W{in_signed & b[B_W-1]}}, b};

    logic [NSL-1:0][P_W-1:0] pp;

    always_comb begin
        for (int j = 0; j < NSL; j++)
            pp[j] = pp_term(a_x[2*j +: 2], (j == NSL - 1) && in_signed, b_x) << (2 * j);
    end

`ifdef MUL_ROUND_EN
    // Signedness is needed again only for the rounding shift.
    logic [STAGES-1:0] sg_pipe;
    assign sg_pipe[0] = in_signed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < STAGES; i++) sg_pipe[i] <= 1'b0;
        end else begin
            for (int i = 1; i < STAGES; i++)
                if (ld[i-1] && up[i-1]) sg_pipe[i] <= sg_pipe[i-1];
        end
    end
`endif

    for (genvar s = 0; s < STAGES; s++) begin : stg
        localparam int NO = n_of(s);
        localparam int NI = (s == 0) ? NSL : n_of(s - 1);

        logic [NI-1:0][P_W-1:0] src;
        logic [NO-1:0][P_W-1:0] sum;
        logic [NO-1:0][P_W-1:0] nxt;
        logic [NO-1:0][P_W-1:0] q;

        if (s == 0) begin : g_first
            assign src = pp;
        end else begin : g_next
            assign src = stg[s-1].q;
        end

        always_comb begin
            sum = '0;
            for (int i = 0; i < NI; i++)
                sum[i % NO] = sum[i % NO] + src[i];
        end

        if (s == STAGES - 1) begin : g_last
`ifdef MUL_ROUND_EN
            if (FRAC_W > 0) begin : g_rnd
                localparam logic [P_W:0] RND = (P_W + 1)'(1) << (FRAC_W - 1);
                logic [P_W:0] rs;
                // One extra bit keeps the rounding add from overflowing.
                assign rs = {sg_pipe[s] & sum[0][P_W-1], sum[0]} + RND;
                assign nxt[0] = sg_pipe[s] ? P_W'($signed(rs) >>> FRAC_W) : P_W'(rs >> FRAC_W);
            end else begin : g_raw
                assign nxt[0] = sum[0];
            end
`else
            assign nxt = sum;
`endif
            assign c = q[0];
        end else begin : g_mid
            assign nxt = sum;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)                   q <= '0;
            else if (ld[s] && up[s])   q <= nxt;
        end
    end

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe (A_W=8, B_W=12, STAGES=3); the monitor pops on every consumed output.
module tb_mul_pipe;
    localparam int A_W = 8, B_W = 12, STAGES = 3, FRAC_W = 8, P_W = 20;
`ifdef MUL_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic           clk = 1'b0, rst = 1'b1;
    logic           in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
    logic [A_W-1:0] a = '0;
    logic [B_W-1:0] b = '0;
    logic           in_ready, out_valid;
    logic [P_W-1:0] c;

    int             n_chk = 0, n_pass = 0, occ = 0;
    bit             rnd_ready = 1'b0;
    logic [P_W-1:0] exp_q[$];

    mul_pipe #(.A_W(A_W), .B_W(B_W), .STAGES(STAGES), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .c(c)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, got, want);
    endtask

    task automatic miss(input string nm);
        n_chk++;
        $display("FAIL %s: got timeout required event", nm);
    endtask

    function automatic logic [P_W-1:0] model(input logic [A_W-1:0] x, input logic [B_W-1:0] y,
                                             input logic s);
        longint px, py, p;
        px = s ? longint'($signed(x)) : longint'(x);
        py = s ? longint'($signed(y)) : longint'(y);
        p  = px * py;
        if (RND) p = (p + (longint'(1) << (FRAC_W - 1))) >>> FRAC_W;
        return p[P_W-1:0];
    endfunction

    // Hand-derived product for the default build; the rounding build recomputes.
    function automatic logic [P_W-1:0] hand(input logic [P_W-1:0] h, input logic [A_W-1:0] x,
                                            input logic [B_W-1:0] y, input logic s);
        return RND ? model(x, y, s) : h;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            occ = 0;
        end else begin
            chk("in_ready_vs_occupancy", in_ready, (occ < STAGES) || out_ready);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_output: got c=%0h required no output", c);
                end else begin
                    chk("c", c, exp_q.pop_front());
                end
            end
            occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [A_W-1:0] x, input logic [B_W-1:0] y, input logic s,
                        input logic [P_W-1:0] e);
        int t;
        a = x; b = y; in_signed = s; in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) miss("accept");
        else exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            t++;
            @(posedge clk);
        end
        if (exp_q.size() != 0) miss("drain");
        @(posedge clk); #1;
    endtask

    // Unsigned max with exact latency: out_valid rises STAGES cycles after acceptance.
    task automatic latency_check();
        a = 8'hFF; b = 12'hFFF; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("max_accept", in_ready, 1);
        exp_q.push_back(hand(20'hFEF01, 8'hFF, 12'hFFF, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= STAGES; k++) begin
            @(negedge clk);
            chk("latency_out_valid", out_valid, (k == STAGES));
        end
        @(negedge clk);
        chk("max_out_valid_drops", out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [A_W-1:0] x;
        logic [B_W-1:0] y;
        logic           s;
        int             seed;

        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_c", c, 0);
        chk("reset_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        latency_check();

        send(8'h80, 12'h800, 1'b1, hand(20'h40000, 8'h80, 12'h800, 1'b1));
        send(8'hFF, 12'h001, 1'b1, hand(20'hFFFFF, 8'hFF, 12'h001, 1'b1));
        send(8'h80, 12'h800, 1'b0, hand(20'h40000, 8'h80, 12'h800, 1'b0));
        send(8'hFF, 12'h001, 1'b0, hand(20'h000FF, 8'hFF, 12'h001, 1'b0));
        drain();

        // Back-pressure: three fill the pipe, the fourth waits.
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++)
            send(A_W'(i), B_W'(i + 1), 1'b0, hand(P_W'(i * (i + 1)), A_W'(i), B_W'(i + 1), 1'b0));
        a = 8'd4; b = 12'd5; in_signed = 1'b0; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_c", c, hand(20'd2, 8'd1, 12'd2, 1'b0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 4; i <= 8; i++)
            send(A_W'(i), B_W'(i + 1), 1'b0, hand(P_W'(i * (i + 1)), A_W'(i), B_W'(i + 1), 1'b0));
        drain();

        // Bubbles with random back-pressure.
        seed = $urandom(32'd1234);
        rnd_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            x = A_W'($urandom);
            y = B_W'($urandom);
            s = 1'($urandom_range(0, 1));
            send(x, y, s, model(x, y, s));
            @(posedge clk); #1;
        end
        rnd_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Reset with three results in flight.
        out_ready = 1'b0;
        send(8'd5, 12'd6, 1'b0, 20'd30);
        send(8'd7, 12'd8, 1'b0, 20'd56);
        send(8'd9, 12'd10, 1'b0, 20'd90);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_c", c, 0);
        chk("midreset_in_ready", in_ready, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.delete();
        occ = 0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("flushed_out_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        latency_check();

`ifdef MUL_ROUND_EN
        send(8'd3, 12'h0AB, 1'b0, 20'd2);
        send(8'hFF, 12'h080, 1'b1, 20'd0);
        send(8'hFF, 12'h180, 1'b1, 20'hFFFFF);
        drain();
`endif

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Parametrised, pipelined A_W x B_W integer multiplier with valid/ready flow control and per-transaction signed/unsigned mode.
- Successor to the fixed 2x4 unsigned registered multiplier; serves the ZOOM scaler datapath (pixel x interpolation coefficient).
- Pipeline depth is set by STAGES; the pipeline collapses bubbles and stalls without loss under back-pressure.

Parameters:
- A_W, 8: width of operand a (2..16).
- B_W, 12: width of operand b (2..16).
- STAGES, 3: pipeline register stages from input to c (1..4).
- FRAC_W, 8: fraction bits removed when MUL_ROUND_EN is defined (0..A_W+B_W-1); unused otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  a, b and in_signed are valid this cycle.
- in_ready  out  1  block accepts input this cycle.
- in_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- a  in  A_W  operand a.
- b  in  B_W  operand b.
- out_valid  out  1  c holds a result.
- out_ready  in  1  downstream accepts c this cycle.
- c  out  A_W+B_W  product (see MUL_ROUND_EN).

Behaviour:
- Reset, asynchronous: all stage valid bits, out_valid and c clear to 0; in_ready = 0 while rst = 1. No pending result survives reset; reset may occur mid-operation.
- Stages 0..STAGES-1 each hold a valid bit plus data; the last stage drives out_valid and c.
- Load rule: last stage loads when !v[S-1] | out_ready; stage i loads when !v[i] | load[i+1]. in_ready = load[0] (combinational, no dependency on in_valid).
- Transfer: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
- A stage that loads while its upstream is empty clears its valid bit.
- Latency: exactly STAGES cycles from acceptance to out_valid with out_ready held at 1. Throughput: 1 result per cycle.
- Stall: with out_ready = 0, c and out_valid hold stable. Up to STAGES transactions are buffered; in_ready = 0 only when all stages are valid and out_ready = 0.
- Simultaneous accept and consume on a full pipe is allowed; no loss, no duplication. Results leave in acceptance order.
- Arithmetic: c = a*b exact in A_W+B_W bits.
  - in_signed = 0: operands zero-extended.
  - in_signed = 1: operands sign-extended; the result is two's complement. -2^(A_W-1) x -2^(B_W-1) fits without overflow.
- Structure: a is split into 2-bit slices; slice x b partial products are formed and summed across stages (adder tree split evenly over STAGES). in_signed travels with its data.

Optional Feature:
- Macro: MUL_ROUND_EN.
- Defined: c = (product + 2^(FRAC_W-1)) >> FRAC_W.
  - Arithmetic shift when in_signed = 1, logical when 0; round-half-up toward +inf.
  - Result is sign- or zero-extended to A_W+B_W bits.
  - FRAC_W = 0 gives the raw product.
  - Rounding is added in the final stage; latency unchanged.
- Not defined: c = full exact product; FRAC_W ignored.

Test Plan (A_W=8, B_W=12, STAGES=3 unless noted):
- Unsigned max: a=0xFF, b=0xFFF, in_signed=0, accepted at cycle 0, out_ready=1 -> out_valid at cycle 3, c=0xFEF01 (1044225), then out_valid=0.
- Signed corners: (a=0x80, b=0x800, in_signed=1) then (a=0xFF, b=0x001, in_signed=1) back-to-back -> c=0x40000 then c=0xFFFFF on consecutive cycles. The same operands with in_signed=0 -> c=0x40000 and c=0x000FF.
- Back-pressure: 8 consecutive inputs a=i, b=i+1, out_ready=0 from cycle 0 -> in_ready=0 after 3 accepted, c=0x00002 held stable. Raise out_ready -> results 2, 6, 12, ... 72 in order, none lost or duplicated.
- Bubbles: in_valid toggling 1/0, out_ready random (seeded) -> output sequence equals a scoreboard of products; whenever a stage is empty, in_ready=1 regardless of out_ready.
- Reset mid-flight: 3 transactions in pipe, rst=1 for 1 cycle asynchronously -> out_valid=0 and c=0 immediately, no result of the 3 appears after release, next input behaves as in the first scenario.
- MUL_ROUND_EN, FRAC_W=8:
  - a=3, b=0x0AB, unsigned -> c=2 (513+128 >> 8).
  - a=0xFF, b=0x080, signed -> c=0 (-128 rounds to 0).
  - a=0xFF, b=0x180, signed -> c=0xFFFFF (-384 -> -1).
